// File: rtl/mc_seq_datapath.sv
// Sequential half of the multi-cycle MIPS core: state register, PC/IR/MDR/A/B/ALUOut and output muxes.
// Optional memory wait states are enabled with the MC_SEQ_MEM_WAIT_EN macro.
module mc_seq_datapath #(
  parameter logic [31:0] PC_RESET   = 32'h0000_0000,
  parameter int          NUM_STATES = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  ns,
  input  logic        pc_wr,
  input  logic        pc_wr_cond,
  input  logic        iord,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic        ir_wr,
  input  logic        mem_to_reg,
  input  logic        reg_dst,
  input  logic [1:0]  pc_src,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic [31:0] mem_rdata,
  input  logic [31:0] rf_rd1,
  input  logic [31:0] rf_rd2,
`ifdef MC_SEQ_MEM_WAIT_EN
  input  logic        mem_ready,
  output logic        stall,
`endif
  output logic [3:0]  s,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic [31:0] a_reg,
  output logic [31:0] b_reg,
  output logic [31:0] alu_out,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rd_o,
  output logic        mem_wr_o,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        illegal
);

  localparam logic [4:0] NS_LIMIT = 5'(NUM_STATES);

  logic        stall_s;
  logic        ns_legal_s;
  logic        pc_we_s;
  logic        pc_load_s;
  logic [31:0] pc_next_s;
  logic [31:0] mdr_r;

`ifdef MC_SEQ_MEM_WAIT_EN
  assign stall_s = (mem_rd | mem_wr) & ~mem_ready;
  assign stall   = stall_s;
`else
  assign stall_s = 1'b0;
`endif

  // An NS with unknown bits makes this compare unknown, which steers the if below to its illegal branch.
  assign ns_legal_s = ({1'b0, ns} < NS_LIMIT);

  // PC source select; pc_src=11 never writes.
  always_comb begin
    pc_we_s   = pc_wr | (pc_wr_cond & alu_zero);
    pc_next_s = pc;
    pc_load_s = 1'b0;
    case (pc_src)
      2'b00: begin
        pc_next_s = alu_result;
        pc_load_s = pc_we_s;
      end
      2'b01: begin
        pc_next_s = alu_out;
        pc_load_s = pc_we_s;
      end
      2'b10: begin
        pc_next_s = {pc[31:28], ir[25:0], 2'b00};
        pc_load_s = pc_we_s;
      end
      default: begin
        pc_next_s = pc;
        pc_load_s = 1'b0;
      end
    endcase
  end

  // Architectural registers; reset wins over stall, and a stall freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      s       <= 4'd0;
      illegal <= 1'b0;
      pc      <= PC_RESET;
      ir      <= 32'h0000_0000;
      mdr_r   <= 32'h0000_0000;
      a_reg   <= 32'h0000_0000;
      b_reg   <= 32'h0000_0000;
      alu_out <= 32'h0000_0000;
    end else if (!stall_s) begin
      if (ns_legal_s) begin
        s <= ns;
      end else begin
        s       <= 4'd0;
        illegal <= 1'b1;
      end
      if (pc_load_s) begin
        pc <= pc_next_s;
      end
      if (ir_wr) begin
        ir <= mem_rdata;
      end
      mdr_r   <= mem_rdata;
      a_reg   <= rf_rd1;
      b_reg   <= rf_rd2;
      alu_out <= alu_result;
    end
  end

  assign op        = ir[31:26];
  assign funct     = ir[5:0];
  assign mem_addr  = iord ? alu_out : pc;
  assign mem_wdata = b_reg;
  assign rf_waddr  = reg_dst ? ir[15:11] : ir[20:16];
  assign rf_wdata  = mem_to_reg ? mdr_r : alu_out;
  assign mem_rd_o  = mem_rd & ~stall_s;
  assign mem_wr_o  = mem_wr & ~stall_s;

endmodule

// File: tb/tb_mc_seq_datapath.sv
// Self-checking bench for mc_seq_datapath: directed scenarios plus randomized cycles against a
// behavioural model of the architectural registers.
module tb_mc_seq_datapath;

  localparam logic [31:0] PC_RESET   = 32'h0000_0000;
  localparam int          NUM_STATES = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ns;
  logic        pc_wr, pc_wr_cond, iord, mem_rd, mem_wr, ir_wr, mem_to_reg, reg_dst;
  logic [1:0]  pc_src;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [31:0] mem_rdata, rf_rd1, rf_rd2;
`ifdef MC_SEQ_MEM_WAIT_EN
  logic        mem_ready;
  logic        stall;
`endif
  logic [3:0]  s;
  logic [5:0]  op, funct;
  logic [31:0] pc, ir, a_reg, b_reg, alu_out, mem_addr, mem_wdata, rf_wdata;
  logic        mem_rd_o, mem_wr_o, illegal;
  logic [4:0]  rf_waddr;

  mc_seq_datapath #(.PC_RESET(PC_RESET), .NUM_STATES(NUM_STATES)) dut (
    .clk(clk), .rst(rst), .ns(ns),
    .pc_wr(pc_wr), .pc_wr_cond(pc_wr_cond), .iord(iord), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .ir_wr(ir_wr), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .pc_src(pc_src),
    .alu_result(alu_result), .alu_zero(alu_zero), .mem_rdata(mem_rdata),
    .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
`ifdef MC_SEQ_MEM_WAIT_EN
    .mem_ready(mem_ready), .stall(stall),
`endif
    .s(s), .op(op), .funct(funct), .pc(pc), .ir(ir), .a_reg(a_reg), .b_reg(b_reg),
    .alu_out(alu_out), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model of the architectural state.
  logic [3:0]  m_s;
  logic        m_ill;
  logic [31:0] m_pc, m_ir, m_mdr, m_a, m_b, m_ao;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic model_stall();
`ifdef MC_SEQ_MEM_WAIT_EN
    return (mem_rd | mem_wr) & ~mem_ready;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_edge();
    logic [31:0] npc;
    if (rst) begin
      m_s = 4'd0; m_ill = 1'b0; m_pc = PC_RESET;
      m_ir = 32'd0; m_mdr = 32'd0; m_a = 32'd0; m_b = 32'd0; m_ao = 32'd0;
    end else if (!model_stall()) begin
      npc = m_pc;
      if (pc_wr || (pc_wr_cond && alu_zero)) begin
        if (pc_src == 2'd0) npc = alu_result;
        else if (pc_src == 2'd1) npc = m_ao;
        else if (pc_src == 2'd2) npc = {m_pc[31:28], m_ir[25:0], 2'b00};
      end
      m_pc = npc;
      if (ir_wr) m_ir = mem_rdata;
      if (int'(ns) < NUM_STATES) m_s = ns;
      else begin
        m_s = 4'd0;
        m_ill = 1'b1;
      end
      m_mdr = mem_rdata; m_a = rf_rd1; m_b = rf_rd2; m_ao = alu_result;
    end
  endtask

  task automatic idle();
    rst = 1'b0; ns = 4'd0; pc_wr = 1'b0; pc_wr_cond = 1'b0; iord = 1'b0;
    mem_rd = 1'b0; mem_wr = 1'b0; ir_wr = 1'b0; mem_to_reg = 1'b0; reg_dst = 1'b0;
    pc_src = 2'b11; alu_result = 32'd0; alu_zero = 1'b0; mem_rdata = 32'd0;
    rf_rd1 = 32'd0; rf_rd2 = 32'd0;
`ifdef MC_SEQ_MEM_WAIT_EN
    mem_ready = 1'b1;
`endif
  endtask

  // One clock: check the combinational outputs mid-cycle, then advance and check registers.
  task automatic cycle();
    logic st;
    #3;
    st = model_stall();
    check("mem_addr", mem_addr, iord ? m_ao : m_pc);
    check("mem_wdata", mem_wdata, m_b);
    check("rf_waddr", {27'd0, rf_waddr}, {27'd0, reg_dst ? m_ir[15:11] : m_ir[20:16]});
    check("rf_wdata", rf_wdata, mem_to_reg ? m_mdr : m_ao);
    check("mem_rd_o", {31'd0, mem_rd_o}, {31'd0, mem_rd & ~st});
    check("mem_wr_o", {31'd0, mem_wr_o}, {31'd0, mem_wr & ~st});
`ifdef MC_SEQ_MEM_WAIT_EN
    check("stall", {31'd0, stall}, {31'd0, st});
`endif
    model_edge();
    @(posedge clk);
    #1;
    check("s", {28'd0, s}, {28'd0, m_s});
    check("illegal", {31'd0, illegal}, {31'd0, m_ill});
    check("pc", pc, m_pc);
    check("ir", ir, m_ir);
    check("op_funct", {20'd0, op, funct}, {20'd0, m_ir[31:26], m_ir[5:0]});
    check("a_reg", a_reg, m_a);
    check("b_reg", b_reg, m_b);
    check("alu_out", alu_out, m_ao);
  endtask

  initial begin
    m_s = 4'd0; m_ill = 1'b0; m_pc = 32'd0; m_ir = 32'd0;
    m_mdr = 32'd0; m_a = 32'd0; m_b = 32'd0; m_ao = 32'd0;
    idle();
    @(posedge clk);
    #1;

    // Reset with garbage on the control inputs.
    rst = 1'b1; ns = 4'd7; pc_wr = 1'b1; pc_src = 2'b00; alu_result = 32'hDEAD_BEEF; ir_wr = 1'b1;
    mem_rdata = 32'h1234_5678;
    cycle();
    check("rst_s", {28'd0, s}, 32'd0);
    check("rst_pc", pc, PC_RESET);
    check("rst_ir", ir, 32'd0);

    // Fetch.
    idle();
    ns = 4'd1; ir_wr = 1'b1; pc_wr = 1'b1; pc_src = 2'b00; mem_rdata = 32'h8C22_0004;
    alu_result = 32'd4; mem_rd = 1'b1;
    #1 check("fetch_addr", mem_addr, 32'd0);
    cycle();
    check("fetch_s", {28'd0, s}, 32'd1);
    check("fetch_ir", ir, 32'h8C22_0004);
    check("fetch_op", {26'd0, op}, 32'h23);
    check("fetch_pc", pc, 32'd4);

    // Branch: set pc=8, then alu_out=0x20, then not-taken and taken.
    idle(); pc_wr = 1'b1; pc_src = 2'b00; alu_result = 32'd8; cycle();
    idle(); alu_result = 32'h20; cycle();
    idle(); pc_wr_cond = 1'b1; pc_src = 2'b01; alu_zero = 1'b0; alu_result = 32'h20; ns = 4'd2; cycle();
    check("br_not_taken_pc", pc, 32'd8);
    check("br_not_taken_s", {28'd0, s}, 32'd2);
    idle(); pc_wr_cond = 1'b1; pc_src = 2'b01; alu_zero = 1'b1; alu_result = 32'h20; cycle();
    check("br_taken_pc", pc, 32'h20);

    // pc_src=11 holds even with pc_wr.
    idle(); pc_wr = 1'b1; pc_src = 2'b11; alu_result = 32'h44; cycle();
    check("hold_pc", pc, 32'h20);

    // Jump from an already-incremented pc.
    idle(); pc_wr = 1'b1; pc_src = 2'b00; alu_result = 32'h1000_0004;
    ir_wr = 1'b1; mem_rdata = 32'h0800_0010; cycle();
    idle(); pc_wr = 1'b1; pc_src = 2'b10; cycle();
    check("jump_pc", pc, 32'h1000_0040);

    // Illegal state is sticky until reset.
    idle(); ns = 4'hD; cycle();
    check("ill_s", {28'd0, s}, 32'd0);
    check("ill_flag", {31'd0, illegal}, 32'd1);
    idle(); ns = 4'd2; cycle();
    check("ill_sticky", {31'd0, illegal}, 32'd1);
    check("ill_next_s", {28'd0, s}, 32'd2);
    idle(); rst = 1'b1; cycle();
    check("ill_clear", {31'd0, illegal}, 32'd0);
    check("ill_rst_pc", pc, PC_RESET);

    // Writeback muxes.
    idle(); ir_wr = 1'b1; mem_rdata = 32'h0043_0820; cycle();
    idle(); mem_rdata = 32'h55; alu_result = 32'hAA; cycle();
    idle(); mem_rdata = 32'h55; alu_result = 32'hAA; reg_dst = 1'b1; mem_to_reg = 1'b0;
    #1;
    check("wb_waddr_rd", {27'd0, rf_waddr}, 32'd1);
    check("wb_wdata_alu", rf_wdata, 32'hAA);
    cycle();
    idle(); reg_dst = 1'b0; mem_to_reg = 1'b1;
    #1;
    check("wb_waddr_rt", {27'd0, rf_waddr}, 32'd3);
    check("wb_wdata_mdr", rf_wdata, 32'h55);
    cycle();

`ifdef MC_SEQ_MEM_WAIT_EN
    // Memory wait states.
    idle(); ns = 4'd3; mem_rdata = 32'h77; cycle();
    for (int i = 0; i < 3; i++) begin
      idle(); ns = 4'd4; mem_rd = 1'b1; mem_ready = 1'b0; mem_rdata = 32'h99; mem_to_reg = 1'b1;
      #1;
      check("stl_stall", {31'd0, stall}, 32'd1);
      check("stl_rd_o", {31'd0, mem_rd_o}, 32'd0);
      cycle();
      check("stl_s", {28'd0, s}, 32'd3);
      check("stl_mdr", rf_wdata, 32'h77);
    end
    idle(); ns = 4'd4; mem_rd = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h99; mem_to_reg = 1'b1; cycle();
    check("stl_done_s", {28'd0, s}, 32'd4);
    idle(); mem_to_reg = 1'b1; #1 check("stl_done_mdr", rf_wdata, 32'h99);
    idle(); ns = 4'd5; mem_rd = 1'b1; mem_ready = 1'b0; cycle();
    idle(); ns = 4'd5; mem_rd = 1'b1; mem_ready = 1'b0; rst = 1'b1; cycle();
    check("stl_rst_s", {28'd0, s}, 32'd0);
`endif

    // Randomized cycles.
    for (int i = 0; i < 400; i++) begin
      idle();
      rst        = ($urandom_range(0, 39) == 0);
      ns         = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      pc_wr      = ($urandom_range(0, 3) == 0);
      pc_wr_cond = $urandom_range(0, 1) == 1;
      alu_zero   = $urandom_range(0, 1) == 1;
      pc_src     = 2'($urandom_range(0, 3));
      iord       = $urandom_range(0, 1) == 1;
      mem_rd     = $urandom_range(0, 1) == 1;
      mem_wr     = ($urandom_range(0, 3) == 0);
      ir_wr      = ($urandom_range(0, 2) == 0);
      mem_to_reg = $urandom_range(0, 1) == 1;
      reg_dst    = $urandom_range(0, 1) == 1;
      alu_result = $urandom;
      mem_rdata  = $urandom;
      rf_rd1     = $urandom;
      rf_rd2     = $urandom;
`ifdef MC_SEQ_MEM_WAIT_EN
      mem_ready  = ($urandom_range(0, 2) != 0);
`endif
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
